simplez_ctrl: RTL and testbench
===============================

Name: simplez_ctrl

Overview:
- Control unit (sequencer) for the SIMPLEZ datapath.
- Sequences the eight-instruction ISA by driving the datapath micro-orders: RA, CP, RI, AC, memory read/write and bus enables.
- Adds a memory-ready handshake on read cycles, a latched opcode, and a resumable HALT state.
- Sits between the RI/AC registers and the datapath's load/enable inputs inside the simplez top level.

Parameters:
- HALT_RESUME, 1: 1 = HALT state exits on cont; 0 = HALT is sticky until reset.

Ports:
- clk  in  1  system clock; all state updates on falling edge, matching datapath registers
- rstn  in  1  reset, synchronous, active-low
- co  in  3  opcode field RI[11:9]
- ac_zero  in  1  1 when AC == 0
- mem_rdy  in  1  memory read data valid this cycle
- cont  in  1  resume request in HALT
- lec  out  1  memory read enable onto busD
- esc  out  1  memory write strobe
- era  out  1  load RA from busAi
- incp  out  1  CP <= CP+1
- ecp  out  1  CP <= busAi
- ccp  out  1  CP <= 0 (not driven by this ISA; constant 0, kept for datapath compatibility)
- scp  out  1  CP onto busAi
- eri  out  1  load RI from busD
- sri  out  1  RI[8:0] onto busAi
- eac  out  1  load AC from ALU
- sac  out  1  AC onto busD
- alu_op  out  2  0 PASS busD, 1 ADD AC+busD, 2 CLR, 3 DEC AC-1
- stop  out  1  CPU halted
- state_o  out  3  current state, for debug

Behaviour:
- States: I0=0 fetch, I1=1 decode/execute, O0=2 operand, O1=3 finish, HLT=4.
- Opcodes: ST=0, LD=1, ADD=2, BR=3, BZ=4, CLR=5, DEC=6, HALT=7.
- Reset (rstn=0 at falling edge): state<=I0, op_q<=0.
- While rstn=0, every output is forced 0; alu_op=0; state_o reads 0.
- Outputs are combinational decode of (state, op_q/co, mem_rdy, ac_zero, cont). Unlisted outputs are 0.
- I0:
  - lec=1.
  - If mem_rdy: eri=1, incp=1, next I1.
  - Else stay in I0, no eri/incp.
- I1: op_q<=co. Actions per co:
  - ST/LD/ADD: sri=1, era=1; next O0.
  - BR: sri=1, era=1, ecp=1; next I0. Next fetch is from CD; CP becomes CD+1 after that fetch.
  - BZ with ac_zero=1: same as BR.
  - BZ with ac_zero=0: scp=1, era=1; next I0.
  - CLR: eac=1, alu_op=2, scp=1, era=1; next I0.
  - DEC: eac=1, alu_op=3, scp=1, era=1; next I0.
  - HALT: stop=1; next HLT.
- O0 (uses op_q):
  - ST: sac=1, esc=1; next O1. Writes complete in one cycle; mem_rdy is ignored.
  - LD: lec=1. If mem_rdy: eac=1, alu_op=0, next O1. Else stay in O0.
  - ADD: lec=1. If mem_rdy: eac=1, alu_op=1, next O1. Else stay in O0.
  - Any other op_q is unreachable; go to I0 with all outputs 0.
- O1: scp=1, era=1; next I0.
- HLT:
  - stop=1.
  - If HALT_RESUME=1 and cont=1: scp=1, era=1, next I0. Execution resumes at the instruction after HALT.
  - Otherwise stay in HLT.
- Cycle counts with mem_rdy tied 1:
  - CLR/DEC/BR/BZ: 2 cycles.
  - ST/LD/ADD: 4 cycles.
  - HALT: 2 cycles to reach HLT.
- Each mem_rdy=0 cycle in I0/O0 adds exactly one cycle.
- co is sampled only in I1; changes to co in other states have no effect.
- ac_zero is sampled only in I1.
- Reset asserted mid-instruction (any state, including a wait) returns to I0 on the next falling edge. No write strobe is issued in that cycle.
- Undefined state encodings (5-7) go to I0 with outputs 0.
- At most one of {incp, ecp, ccp} is 1 in any cycle.
- At most one busAi driver {scp, sri} is 1 in any cycle.
- At most one busD driver {lec, sac} is 1 in any cycle.

Test Plan:
- Reset, mem_rdy=1, co=5 (CLR) → states I0,I1,I0.
  - I0: lec=eri=incp=1.
  - I1: eac=1, alu_op=2, scp=era=1.
- co=2 (ADD), mem_rdy low for 2 cycles in O0 → states I0,I1,O0,O0,O0,O1,I0.
  - eac=1 with alu_op=1 only in the third O0 cycle.
- co=4 (BZ):
  - ac_zero=1 → I1 shows ecp=sri=era=1.
  - ac_zero=0 → I1 shows scp=era=1 and ecp=0.
- co=0 (ST) → O0 has sac=esc=1 for exactly 1 cycle regardless of mem_rdy=0; O1 has scp=era=1.
- co=7 (HALT) → stop=1 from I1 onward.
  - HALT_RESUME=1: cont=1 after 5 cycles → one cycle with scp=era=1, then I0 fetch.
  - HALT_RESUME=0: cont is ignored.
- rstn=0 for 1 cycle while in O0 waiting on LD → all outputs 0 during reset; state_o=0 next cycle; no eac pulse is emitted.

Source files
------------

// File: rtl/simplez_ctrl.sv
// simplez_ctrl: SIMPLEZ sequencer decoding state/opcode into datapath micro-orders
module simplez_ctrl #(
  parameter bit HALT_RESUME = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] co,
  input  logic       ac_zero,
  input  logic       mem_rdy,
  input  logic       cont,
  output logic       lec,
  output logic       esc,
  output logic       era,
  output logic       incp,
  output logic       ecp,
  output logic       ccp,
  output logic       scp,
  output logic       eri,
  output logic       sri,
  output logic       eac,
  output logic       sac,
  output logic [1:0] alu_op,
  output logic       stop,
  output logic [2:0] state_o
);
  typedef enum logic [2:0] {I0 = 3'd0, I1 = 3'd1, O0 = 3'd2, O1 = 3'd3, HLT = 3'd4} state_t;
  state_t state, next;
  logic [2:0] op_q;
  // Registers update on the falling edge, in step with the datapath.
  always_ff @(negedge clk) begin
    if (!rstn) begin
      state <= I0;
      op_q  <= 3'd0;
    end else begin
      state <= next;
      op_q  <= state == I1 ? co : op_q;
    end
  end
  assign ccp     = 1'b0;
  assign state_o = rstn ? state : 3'd0;
  always_comb begin
    lec = 1'b0; esc = 1'b0; era = 1'b0; incp = 1'b0; ecp = 1'b0; scp = 1'b0;
    eri = 1'b0; sri = 1'b0; eac = 1'b0; sac = 1'b0; alu_op = 2'd0; stop = 1'b0;
    next = I0;
    if (rstn) begin
      case (state)
        I0: begin
          lec  = 1'b1;
          eri  = mem_rdy;
          incp = mem_rdy;
          next = mem_rdy ? I1 : I0;
        end
        I1: begin
          case (co)
            3'd0, 3'd1, 3'd2: begin sri = 1'b1; era = 1'b1; next = O0; end
            3'd3: begin sri = 1'b1; era = 1'b1; ecp = 1'b1; end
            3'd4: begin
              sri = ac_zero;
              ecp = ac_zero;
              scp = !ac_zero;
              era = 1'b1;
            end
            3'd5: begin eac = 1'b1; alu_op = 2'd2; scp = 1'b1; era = 1'b1; end
            3'd6: begin eac = 1'b1; alu_op = 2'd3; scp = 1'b1; era = 1'b1; end
            default: begin stop = 1'b1; next = HLT; end
          endcase
        end
        O0: begin
          case (op_q)
            3'd0: begin sac = 1'b1; esc = 1'b1; next = O1; end
            3'd1, 3'd2: begin
              lec    = 1'b1;
              eac    = mem_rdy;
              alu_op = (mem_rdy && op_q == 3'd2) ? 2'd1 : 2'd0;
              next   = mem_rdy ? O1 : O0;
            end
            default: next = I0;
          endcase
        end
        O1: begin scp = 1'b1; era = 1'b1; end
        HLT: begin
          stop = 1'b1;
          scp  = HALT_RESUME && cont;
          era  = HALT_RESUME && cont;
          next = (HALT_RESUME && cont) ? I0 : HLT;
        end
        default: next = I0;
      endcase
    end
  end
endmodule

// File: tb/tb_simplez_ctrl.sv
// tb_simplez_ctrl: randomized instruction-level scoreboard bench for both HALT_RESUME settings
module tb_simplez_ctrl;
  typedef struct packed {logic [10:0] f; logic [1:0] alu; logic stop; logic [2:0] st;} outs_t;
  typedef struct packed {logic mr, az, ct, res; logic [2:0] c; outs_t e;} item_t;
  typedef struct packed {outs_t e1, e0;} exp_t;
  localparam logic [10:0] LEC = 11'h400, ESC = 11'h200, ERA = 11'h100, INCP = 11'h080,
    ECP = 11'h040, SCP = 11'h010, ERI = 11'h008, SRI = 11'h004, EAC = 11'h002, SAC = 11'h001;
  logic clk = 0, rstn = 0, ac_zero = 0, mem_rdy = 0, cont = 0;
  logic [2:0] co = 0;
  logic lec1, esc1, era1, incp1, ecp1, ccp1, scp1, eri1, sri1, eac1, sac1, stop1;
  logic lec0, esc0, era0, incp0, ecp0, ccp0, scp0, eri0, sri0, eac0, sac0, stop0;
  logic [1:0] alu1, alu0;
  logic [2:0] st1, st0;
  outs_t o1, o0;
  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0;
  bit stuck0 = 0;
  simplez_ctrl #(.HALT_RESUME(1'b1)) dut (.clk(clk), .rstn(rstn), .co(co), .ac_zero(ac_zero),
    .mem_rdy(mem_rdy), .cont(cont), .lec(lec1), .esc(esc1), .era(era1), .incp(incp1), .ecp(ecp1),
    .ccp(ccp1), .scp(scp1), .eri(eri1), .sri(sri1), .eac(eac1), .sac(sac1), .alu_op(alu1),
    .stop(stop1), .state_o(st1));
  simplez_ctrl #(.HALT_RESUME(1'b0)) dut0 (.clk(clk), .rstn(rstn), .co(co), .ac_zero(ac_zero),
    .mem_rdy(mem_rdy), .cont(cont), .lec(lec0), .esc(esc0), .era(era0), .incp(incp0), .ecp(ecp0),
    .ccp(ccp0), .scp(scp0), .eri(eri0), .sri(sri0), .eac(eac0), .sac(sac0), .alu_op(alu0),
    .stop(stop0), .state_o(st0));
  assign o1 = {lec1, esc1, era1, incp1, ecp1, ccp1, scp1, eri1, sri1, eac1, sac1, alu1, stop1, st1};
  assign o0 = {lec0, esc0, era0, incp0, ecp0, ccp0, scp0, eri0, sri0, eac0, sac0, alu0, stop0, st0};
  always #5 clk = ~clk;
  function automatic outs_t ob(logic [10:0] f, logic [1:0] a, logic s, logic [2:0] st);
    return '{f: f, alu: a, stop: s, st: st};
  endfunction
  function automatic logic pick(int v);
    return v < 0 ? 1'($urandom % 2) : 1'(v);
  endfunction
  function automatic item_t mk(int mr, int az, int c, int ct, outs_t e, logic res);
    return '{mr: pick(mr), az: pick(az), ct: pick(ct), res: res,
             c: c < 0 ? 3'($urandom % 8) : 3'(c), e: e};
  endfunction
  task automatic drive(logic r, logic mr, logic az, logic ct, logic [2:0] c, outs_t e1, outs_t e0);
    @(posedge clk);
    #1;
    rstn = r; mem_rdy = mr; ac_zero = az; cont = ct; co = c;
    sb.push_back('{e1: e1, e0: e0});
  endtask
  task automatic reset_cycle(int mr);
    drive(1'b0, pick(mr), pick(-1), pick(-1), 3'($urandom % 8), '0, '0);
    stuck0 = 0;
  endtask
  // Expected cycle sequence of one instruction, built from the ISA timing rules.
  task automatic run(logic [2:0] op, logic az, int nf, int no, int hold, int abort);
    item_t q[$];
    outs_t e0;
    for (int i = 0; i < nf; i++) q.push_back(mk(0, -1, -1, -1, ob(LEC, 0, 0, 0), 0));
    q.push_back(mk(1, -1, -1, -1, ob(LEC | ERI | INCP, 0, 0, 0), 0));
    case (op)
      3'd0, 3'd1, 3'd2: begin
        q.push_back(mk(-1, az, op, -1, ob(SRI | ERA, 0, 0, 1), 0));
        if (op == 3'd0) q.push_back(mk(0, -1, -1, -1, ob(SAC | ESC, 0, 0, 2), 0));
        else begin
          for (int i = 0; i < no; i++) q.push_back(mk(0, -1, -1, -1, ob(LEC, 0, 0, 2), 0));
          q.push_back(mk(1, -1, -1, -1, ob(LEC | EAC, op == 3'd2 ? 2'd1 : 2'd0, 0, 2), 0));
        end
        q.push_back(mk(-1, -1, -1, -1, ob(SCP | ERA, 0, 0, 3), 0));
      end
      3'd3: q.push_back(mk(-1, az, op, -1, ob(SRI | ERA | ECP, 0, 0, 1), 0));
      3'd4: q.push_back(mk(-1, az, op, -1, ob(az ? (SRI | ERA | ECP) : (SCP | ERA), 0, 0, 1), 0));
      3'd5: q.push_back(mk(-1, az, op, -1, ob(EAC | SCP | ERA, 2, 0, 1), 0));
      3'd6: q.push_back(mk(-1, az, op, -1, ob(EAC | SCP | ERA, 3, 0, 1), 0));
      default: begin
        q.push_back(mk(-1, az, op, -1, ob(0, 0, 1, 1), 0));
        for (int i = 0; i < hold; i++) q.push_back(mk(-1, -1, -1, 0, ob(0, 0, 1, 4), 0));
        q.push_back(mk(-1, -1, -1, 1, ob(SCP | ERA, 0, 1, 4), 1));
      end
    endcase
    for (int i = 0; i < q.size(); i++) begin
      if (i == abort) begin
        reset_cycle(1);
        return;
      end
      e0 = (stuck0 || q[i].res) ? ob(0, 0, 1, 4) : q[i].e;
      drive(1'b1, q[i].mr, q[i].az, q[i].ct, q[i].c, q[i].e, e0);
      if (q[i].res) stuck0 = 1;
    end
  endtask
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #3;
      cyc++;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        checks += 2;
        if (o1 !== x.e1) begin
          errors++;
          $display("FAIL resume_dut cycle %0d: got %h expected %h", cyc, o1, x.e1);
        end
        if (o0 !== x.e0) begin
          errors++;
          $display("FAIL sticky_dut cycle %0d: got %h expected %h", cyc, o0, x.e0);
        end
      end
    end
  end
  initial begin
    int op, ab;
    reset_cycle(-1);
    reset_cycle(-1);
    run(3'd5, 1'b0, 0, 0, 0, -1);
    run(3'd2, 1'b0, 0, 2, 0, -1);
    run(3'd4, 1'b1, 0, 0, 0, -1);
    run(3'd4, 1'b0, 0, 0, 0, -1);
    run(3'd0, 1'b0, 0, 0, 0, -1);
    run(3'd7, 1'b0, 0, 0, 5, -1);
    run(3'd3, 1'b0, 1, 0, 0, -1);
    reset_cycle(-1);
    run(3'd1, 1'b0, 1, 3, 0, 4);
    run(3'd6, 1'b1, 2, 0, 0, -1);
    for (int n = 0; n < 250; n++) begin
      op = $urandom % 8;
      ab = ($urandom % 10 == 0) ? int'($urandom % 6) : -1;
      run(3'(op), 1'($urandom % 2), ($urandom % 3 == 0) ? int'($urandom % 3) : 0,
          int'($urandom % 3), int'($urandom % 4), ab);
      if (op == 7) reset_cycle(-1);
    end
    repeat (3) @(posedge clk);
    #4;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
